// File: rtl/pipe_dst_track.sv
// rtl/pipe_dst_track.sv - EXE/MEM/WB destination tracking with load-use stall detection
module pipe_dst_track #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             d_wreg,
    input  logic             d_m2reg,
    input  logic [4:0]       d_rn,
    input  logic [4:0]       d_rs,
    input  logic [4:0]       d_rt,
    input  logic             d_use_rs,
    input  logic             d_use_rt,
    input  logic             flush,
    input  logic             hold,
    output logic             ewreg,
    output logic             em2reg,
    output logic [4:0]       ern,
    output logic             mwreg,
    output logic             mm2reg,
    output logic [4:0]       mrn,
    output logic             wwreg,
    output logic [4:0]       wrn,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cnt
);

    logic rs_hit;
    logic rt_hit;
    logic bubble;
    logic cnt_full;

    // Only a load sitting in EXE can stall; a load in MEM is covered by forwarding.
    assign rs_hit   = d_use_rs & (ern == d_rs);
    assign rt_hit   = d_use_rt & (ern == d_rt);
    assign stall    = ewreg & em2reg & (ern != 5'd0) & (rs_hit | rt_hit);
    assign bubble   = stall | flush;
    assign cnt_full = &stall_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ewreg     <= 1'b0;
            em2reg    <= 1'b0;
            ern       <= 5'd0;
            mwreg     <= 1'b0;
            mm2reg    <= 1'b0;
            mrn       <= 5'd0;
            wwreg     <= 1'b0;
            wrn       <= 5'd0;
            stall_cnt <= '0;
        end else if (!hold) begin
            mwreg  <= ewreg;
            mm2reg <= em2reg;
            mrn    <= ern;
            wwreg  <= mwreg;
            wrn    <= mrn;
            if (bubble) begin
                ewreg  <= 1'b0;
                em2reg <= 1'b0;
                ern    <= 5'd0;
            end else begin
                ewreg  <= d_wreg;
                em2reg <= d_m2reg;
                ern    <= d_rn;
            end
            if (stall && !cnt_full)
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_dst_track.sv
// tb/tb_pipe_dst_track.sv - directed self-checking bench for pipe_dst_track
module tb_pipe_dst_track;

    logic        clock = 1'b0;
    logic        reset;
    logic        d_wreg, d_m2reg, d_use_rs, d_use_rt, flush, hold;
    logic [4:0]  d_rn, d_rs, d_rt;
    logic        ewreg, em2reg, mwreg, mm2reg, wwreg, stall;
    logic [4:0]  ern, mrn, wrn;
    logic [15:0] stall_cnt;
    logic        s_ewreg, s_em2reg, s_mwreg, s_mm2reg, s_wwreg, s_stall;
    logic [4:0]  s_ern, s_mrn, s_wrn;
    logic [1:0]  s_stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    pipe_dst_track #(.CNT_W(16)) dut (
        .clock(clock), .reset(reset), .d_wreg(d_wreg), .d_m2reg(d_m2reg),
        .d_rn(d_rn), .d_rs(d_rs), .d_rt(d_rt), .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
        .flush(flush), .hold(hold), .ewreg(ewreg), .em2reg(em2reg), .ern(ern),
        .mwreg(mwreg), .mm2reg(mm2reg), .mrn(mrn), .wwreg(wwreg), .wrn(wrn),
        .stall(stall), .stall_cnt(stall_cnt)
    );

    pipe_dst_track #(.CNT_W(2)) dut_small (
        .clock(clock), .reset(reset), .d_wreg(d_wreg), .d_m2reg(d_m2reg),
        .d_rn(d_rn), .d_rs(d_rs), .d_rt(d_rt), .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
        .flush(flush), .hold(hold), .ewreg(s_ewreg), .em2reg(s_em2reg), .ern(s_ern),
        .mwreg(s_mwreg), .mm2reg(s_mm2reg), .mrn(s_mrn), .wwreg(s_wwreg), .wrn(s_wrn),
        .stall(s_stall), .stall_cnt(s_stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic wreg, input logic m2reg, input logic [4:0] rn,
                         input logic [4:0] rs, input logic use_rs,
                         input logic [4:0] rt, input logic use_rt);
        d_wreg = wreg; d_m2reg = m2reg; d_rn = rn;
        d_rs = rs; d_use_rs = use_rs; d_rt = rt; d_use_rt = use_rt;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_e"}, {ewreg, em2reg, ern}, 0);
        check({tag, "_m"}, {mwreg, mm2reg, mrn}, 0);
        check({tag, "_w"}, {wwreg, wrn}, 0);
        check({tag, "_cnt"}, stall_cnt, 0);
        check({tag, "_scnt"}, s_stall_cnt, 0);
        check({tag, "_stall"}, stall, 0);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; hold = 1'b0;
        drive(1, 1, 5'd8, 5'd8, 1, 5'd8, 1);
        step(); step();
        check_all_zero("reset");
        reset = 1'b0;
        drive(1, 0, 5'd5, 5'd0, 0, 5'd0, 0);

        // Pass-through latency
        step();
        check("pt_e1", {ewreg, em2reg, ern}, {1'b1, 1'b0, 5'd5});
        check("pt_stall", stall, 0);
        drive(0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        step();
        check("pt_m2", {mwreg, mm2reg, mrn}, {1'b1, 1'b0, 5'd5});
        check("pt_e2", ern, 0);
        step();
        check("pt_w3", {wwreg, wrn}, {1'b1, 5'd5});

        // Load-use: one stall cycle, load then in MEM
        drive(1, 1, 5'd8, 5'd0, 0, 5'd0, 0);
        step();
        drive(1, 0, 5'd9, 5'd8, 1, 5'd0, 0);
        #1 check("lu_stall", stall, 1);
        step();
        check("lu_e", {ewreg, em2reg, ern}, 0);
        check("lu_m", {mwreg, mm2reg, mrn}, {1'b1, 1'b1, 5'd8});
        check("lu_nostall_mem", stall, 0);
        check("lu_cnt", stall_cnt, 1);
        step();
        check("lu_after", {ewreg, ern, wrn}, {1'b1, 5'd9, 5'd8});

        // No false stall
        drive(1, 1, 5'd0, 5'd0, 0, 5'd0, 0);
        step();
        drive(1, 0, 5'd1, 5'd0, 1, 5'd0, 0);
        #1 check("nf_r0", stall, 0);
        drive(1, 1, 5'd8, 5'd0, 0, 5'd0, 0);
        step();
        drive(1, 0, 5'd1, 5'd3, 1, 5'd8, 0);
        #1 check("nf_use_rt0", stall, 0);
        d_use_rt = 1'b1;
        #1 check("rt_stall", stall, 1);
        drive(1, 0, 5'd8, 5'd0, 0, 5'd0, 0);
        step();
        drive(1, 0, 5'd1, 5'd0, 0, 5'd8, 1);
        #1 check("nf_alu", stall, 0);
        check("nf_cnt", stall_cnt, 1);

        // Hold freezes everything during a load-use
        drive(0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        step();
        drive(1, 1, 5'd8, 5'd0, 0, 5'd0, 0);
        step();
        drive(1, 0, 5'd10, 5'd8, 1, 5'd0, 0);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_stall", stall, 1);
            check("hold_e", {ewreg, em2reg, ern}, {1'b1, 1'b1, 5'd8});
            check("hold_mw", {mwreg, mrn, wwreg, wrn}, {1'b0, 5'd0, 1'b1, 5'd8});
            check("hold_cnt", stall_cnt, 1);
        end
        hold = 1'b0;
        step();
        check("hold_rel_e", {ewreg, ern}, 0);
        check("hold_rel_mw", {mm2reg, mrn, wwreg, wrn}, {1'b1, 5'd8, 1'b0, 5'd0});
        check("hold_rel_cnt", stall_cnt, 2);

        // Flush with stall, then flush alone
        drive(1, 1, 5'd8, 5'd0, 0, 5'd0, 0);
        step();
        drive(1, 0, 5'd11, 5'd8, 1, 5'd0, 0);
        flush = 1'b1;
        step();
        check("fs_e", {ewreg, ern}, 0);
        check("fs_cnt", stall_cnt, 3);
        drive(1, 0, 5'd12, 5'd0, 0, 5'd0, 0);
        step();
        flush = 1'b0;
        check("fl_e", {ewreg, ern}, 0);
        check("fl_cnt", stall_cnt, 3);

        // Destination pass-through for wreg=0 and rn=0
        drive(0, 0, 5'd7, 5'd0, 0, 5'd0, 0);
        step();
        check("nowreg", {ewreg, ern}, {1'b0, 5'd7});
        drive(1, 0, 5'd0, 5'd0, 0, 5'd0, 0);
        step();
        check("rn0", {ewreg, ern}, {1'b1, 5'd0});

        // Two more load-use stalls: 5 total, the 2-bit counter saturates
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 5'd8, 5'd0, 0, 5'd0, 0);
            step();
            drive(1, 0, 5'd9, 5'd8, 1, 5'd0, 0);
            step();
        end
        check("sat_cnt16", stall_cnt, 5);
        check("sat_cnt2", s_stall_cnt, 3);

        // Asynchronous reset mid-stall
        drive(1, 1, 5'd8, 5'd0, 0, 5'd0, 0);
        step();
        drive(1, 0, 5'd9, 5'd8, 1, 5'd0, 0);
        #1 check("rst_pre_stall", stall, 1);
        #2 reset = 1'b1;
        #1 check_all_zero("rst_async");
        step();
        check_all_zero("rst_edge");
        reset = 1'b0;
        drive(1, 0, 5'd13, 5'd0, 0, 5'd0, 0);
        step();
        check("rst_rel", {ewreg, em2reg, ern}, {1'b1, 1'b0, 5'd13});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_dst_track.md
PIPE_DST_TRACK -- requirements
Module: pipe_dst_track

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the width of the load-use stall counter.
REQ-002 The block SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port d_wreg, input, 1, ID-stage instruction writes the register file.
REQ-005 The block SHALL have port d_m2reg, input, 1, ID-stage instruction is a load (result from memory).
REQ-006 The block SHALL have port d_rn, input, 5, ID-stage destination register number.
REQ-007 The block SHALL have ports d_rs and d_rt, input, 5 each, ID-stage source register numbers.
REQ-008 The block SHALL have ports d_use_rs and d_use_rt, input, 1 each, ID-stage instruction reads rs / rt.
REQ-009 The block SHALL have port flush, input, 1, cancel the ID-stage instruction (taken branch/jump).
REQ-010 The block SHALL have port hold, input, 1, global freeze (memory wait).
REQ-011 The block SHALL have ports ewreg, em2reg, input-side copies for EXE stage: output, 1 each; ern output, 5.
REQ-012 The block SHALL have ports mwreg, mm2reg, output, 1 each; mrn output, 5; MEM-stage copies.
REQ-013 The block SHALL have ports wwreg, output, 1; wrn, output, 5; WB-stage copies.
REQ-014 The block SHALL have port stall, output, 1, load-use hazard: ID and IF must hold, EXE receives a bubble.
REQ-015 The block SHALL have port stall_cnt, output, CNT_W, count of stall cycles taken.

Function
REQ-016 stall SHALL be combinational: ewreg & em2reg & (ern != 0) & ((d_use_rs & ern == d_rs) | (d_use_rt & ern == d_rt)).
REQ-017 stall SHALL depend only on current EXE-stage registers and ID inputs; it SHALL be valid even while hold is high.
REQ-018 On a rising edge with hold low: MEM registers <= EXE registers; WB registers <= MEM registers (wwreg<=mwreg, wrn<=mrn).
REQ-019 On that edge, if stall or flush is high, EXE registers SHALL load a bubble: ewreg=0, em2reg=0, ern=0.
REQ-020 Otherwise EXE registers SHALL load ewreg<=d_wreg, em2reg<=d_m2reg, ern<=d_rn.
REQ-021 A D-stage instruction with d_wreg=0 SHALL still load ern as given; d_rn=0 with d_wreg=1 SHALL pass unchanged (consumers ignore r0).
REQ-022 stall and flush together SHALL produce exactly one bubble, identical to either alone.
REQ-023 With hold high, every stage register and stall_cnt SHALL keep its value; hold has priority over stall and flush.
REQ-024 Pipeline latency SHALL be one clock per stage: ID value appears on E outputs after 1 edge, M after 2, W after 3 (no hold/stall).
REQ-025 stall_cnt SHALL increment by 1 on each edge with stall=1 and hold=0, saturating at all-ones (no wrap).
REQ-026 A load followed by a dependent instruction SHALL stall exactly one cycle; after the bubble the load is in MEM and stall deasserts.
REQ-027 A load in MEM (mm2reg=1) SHALL NOT cause stall; that case is resolved by forwarding downstream.

Reset
REQ-028 While reset is high, all outputs registers SHALL be 0: ewreg, em2reg, ern, mwreg, mm2reg, mrn, wwreg, wrn, stall_cnt.
REQ-029 Reset SHALL take effect immediately without a clock edge and override hold, stall and flush; stall then reads 0 since ewreg=0.
REQ-030 Reset asserted mid-stall SHALL clear the in-flight bubble and counter; first edge after release loads D inputs normally.

Verification
REQ-031 Pass-through: D = (wreg=1, m2reg=0, rn=5) then idle zeros -> ern=5 after edge 1, mrn=5 after edge 2, wrn=5/wwreg=1 after edge 3; stall stays 0.
REQ-032 Load-use: EXE holds load rn=8 (ewreg=1, em2reg=1), D reads rs=8 use_rs=1 -> stall=1; next edge ewreg=0, ern=0, mrn=8, mm2reg=1, stall=0, stall_cnt=1.
REQ-033 No false stall: EXE load rn=0, D rs=0 -> stall=0; EXE load rn=8, D rt=8 but use_rt=0 -> stall=0; EXE ALU op rn=8 (em2reg=0) -> stall=0.
REQ-034 Hold: during load-use, assert hold 3 cycles -> all stage outputs and stall_cnt frozen, stall stays 1; release -> one bubble, stall_cnt +1 only.
REQ-035 Flush and stall together: both high one edge -> ewreg=0, ern=0, stall_cnt +1; flush alone with valid D -> bubble, stall_cnt unchanged.
REQ-036 Saturation and reset: CNT_W=2, force 5 stall edges -> stall_cnt=3; assert reset between edges -> all outputs 0 immediately.
